keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//  Drives a 3x4 matrix keypad (keys 1-9, *, 0, #) by column scanning, samples the row lines,
//  debounces, and presents the pressed key as a 12-bit one-hot code with a valid level.
//  Feeds the 7-segment display writer (Scan_data/valid input side), which captures Scan_data on valid's rising edge.
//  One key per press; multi-key chords are rejected.
// PARAMETERS
//  SCAN_DIV      4     clk cycles each column is driven (dwell); rows sampled on last dwell cycle
//  DEBOUNCE_CNT  3     consecutive identical frames required to accept a press or release (>=1)
//  REPEAT_FRAMES 50    frames a key must stay held before auto-repeat (only with KEYPAD_AUTO_REPEAT_EN)
// PORTS
//  clk        in   1   system clock
//  rst        in   1   synchronous reset, active-high
//  key_row    in   4   keypad rows, 1 = pressed on the driven column; row0 = top
//  key_col    out  3   column drive, one-hot active-high; col0 = left
//  Scan_data  out  12  one-hot key code: bit0-9 = digit 0-9, bit10 = '*', bit11 = '#'
//  valid      out  1   high while an accepted key is held; Scan_data stable whenever valid = 1
// BEHAVIOUR
//  Reset (rst = 1 at posedge clk): key_col = 3'b001; Scan_data = 0; valid = 0; all counters = 0; state = IDLE.
//  Scan:
//   - key_col rotates 001 -> 010 -> 100 -> 001, advancing after SCAN_DIV cycles.
//   - Frame = 3*SCAN_DIV cycles. key_row is sampled on the last dwell cycle into a 12-bit raw frame code.
//  Key map (row, col):
//   - r0: 1 2 3
//   - r1: 4 5 6
//   - r2: 7 8 9
//   - r3: * 0 #
//  Frame code at frame end:
//   - One-hot mapped key if exactly one key is pressed.
//   - Otherwise 0: no key, or 2+ keys (ghosting/chord).
//  Debounce:
//   - stable_cnt increments when frame code equals previous frame code, else reloads to 1.
//   - stable_cnt saturates at DEBOUNCE_CNT.
//   - "Stable" = stable_cnt == DEBOUNCE_CNT.
//  States:
//   - IDLE: stable nonzero code -> LOAD.
//   - LOAD (1 cycle): Scan_data <= code -> PRESS.
//   - PRESS: valid = 1 (rises the cycle after Scan_data updates, so the display's edge capture sees settled data).
//       - Stable code different from Scan_data (0 or another key) -> valid = 0.
//       - Then IDLE if code = 0, else LOAD (new key reported after >=1 cycle low).
//  Release:
//   - Scan_data is held after release (not cleared); only valid falls.
//   - Bounce shorter than DEBOUNCE_CNT frames causes no change in any state.
//  Reset mid-press: everything returns to reset values within that cycle. A still-held key is re-reported after
//   DEBOUNCE_CNT full frames.
//  key_row is assumed synchronised externally; the block adds no synchroniser.
// CONFIGURATION
//  KEYPAD_AUTO_REPEAT_EN defined:
//   - In PRESS, a hold counter counts frames; after REPEAT_FRAMES frames valid drops for exactly 1 cycle and
//     re-asserts.
//   - Repeats again every REPEAT_FRAMES frames while held.
//   - Scan_data is unchanged. Counter clears on leaving PRESS.
//  Undefined: no hold counter; one valid rising edge per press regardless of hold time.
// TESTING (SCAN_DIV=4, DEBOUNCE_CNT=3, cycle 0 = first cycle after rst deasserts)
//  1. Reset: assert rst 2 cycles with key '5' held
//     -> key_col=001, Scan_data=0, valid=0 during reset; key_col=010 at cycle 4.
//  2. Hold '5' (key_row=4'b0010 while key_col=010) from cycle 0
//     -> Scan_data=12'h020 at cycle 36, valid=1 at 37.
//     Release at cycle 60 -> valid=0 after 3 zero frames; Scan_data stays 12'h020.
//  3. '#' held with row3 dropping for 1 frame in every 2
//     -> no valid. Then steady 3 frames -> Scan_data=12'h800, valid=1.
//  4. Hold '1' and '2' together
//     -> Scan_data=0, valid=0 indefinitely.
//     Release '2' -> Scan_data=12'h002, valid rises after 3 frames.
//  5. Hold '0' until valid=1, then switch directly to '*'
//     -> valid falls, Scan_data=12'h400, valid re-rises >=1 cycle later.
//  6. With KEYPAD_AUTO_REPEAT_EN, REPEAT_FRAMES=4: hold '7'
//     -> valid 1-cycle low pulse every 48 cycles after first assertion.
//     Without the macro -> valid stays high.

Source files
------------

// File: rtl/keypad_scanner.sv
// 3x4 matrix keypad scanner: column scan, frame-level debounce, one-hot key code with valid level.
// Optional feature: define KEYPAD_AUTO_REPEAT_EN to pulse valid low every REPEAT_FRAMES frames while a key is held.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV      = 4,
    parameter int unsigned DEBOUNCE_CNT  = 3,
    parameter int unsigned REPEAT_FRAMES = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  key_row,
    output logic [2:0]  key_col,
    output logic [11:0] Scan_data,
    output logic        valid
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CNT);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_PRESS = 2'd2;

    if (SCAN_DIV == 0 || DEBOUNCE_CNT == 0 || REPEAT_FRAMES == 0) begin : g_param_check
        $error("keypad_scanner: SCAN_DIV, DEBOUNCE_CNT and REPEAT_FRAMES must be >= 1");
    end

    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       key_col_q, key_col_d;
    logic [11:0]      raw_q, raw_d;
    logic [11:0]      prev_q, prev_d;
    logic [CNT_W-1:0] stable_cnt_q, stable_cnt_d;
    logic [1:0]       state_q, state_d;
    logic [11:0]      scan_data_q, scan_data_d;
    logic             valid_q, valid_d;

    logic             sample;
    logic             frame_end;
    logic             single_key;
    logic [11:0]      frame_code;
    logic             stable;

`ifdef KEYPAD_AUTO_REPEAT_EN
    localparam int unsigned HOLD_W = (REPEAT_FRAMES > 1) ? $clog2(REPEAT_FRAMES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(REPEAT_FRAMES - 1);
    logic [HOLD_W-1:0] hold_q, hold_d;
`endif

    // raw_q holds pressed positions indexed row*3+col; the last column is merged in combinationally at frame end
    always_comb begin
        sample    = (div_q == DIV_LAST);
        frame_end = sample && key_col_q[2];
        div_d     = sample ? '0 : div_q + 1'b1;
        key_col_d = sample ? {key_col_q[1:0], key_col_q[2]} : key_col_q;
        raw_d     = raw_q;
        if (sample) begin
            for (int unsigned r = 0; r < 4; r++) begin
                for (int unsigned c = 0; c < 3; c++) begin
                    if (key_col_q[c]) raw_d[r*3 + c] = key_row[r];
                end
            end
        end
        single_key = (raw_d != '0) && ((raw_d & (raw_d - 12'd1)) == '0);
        frame_code = single_key ? {raw_d[11], raw_d[9], raw_d[8:0], raw_d[10]} : '0;
    end

    always_comb begin
        prev_d       = prev_q;
        stable_cnt_d = stable_cnt_q;
        if (frame_end) begin
            prev_d = frame_code;
            if (frame_code == prev_q) begin
                stable_cnt_d = (stable_cnt_q == CNT_MAX) ? CNT_MAX : stable_cnt_q + 1'b1;
            end else begin
                stable_cnt_d = CNT_W'(1);
            end
        end
        stable = frame_end && (stable_cnt_d == CNT_MAX);
    end

    // Scan_data is loaded on entry to LOAD so valid rises one cycle after the data settles
    always_comb begin
        state_d     = state_q;
        scan_data_d = scan_data_q;
        valid_d     = valid_q;
`ifdef KEYPAD_AUTO_REPEAT_EN
        hold_d      = hold_q;
`endif
        case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
                if (stable && frame_code != '0) begin
                    scan_data_d = frame_code;
                    state_d     = ST_LOAD;
                end
            end
            ST_LOAD: begin
                valid_d = 1'b1;
                state_d = ST_PRESS;
`ifdef KEYPAD_AUTO_REPEAT_EN
                hold_d  = '0;
`endif
            end
            ST_PRESS: begin
                valid_d = 1'b1;
                if (stable && frame_code != scan_data_q) begin
                    valid_d = 1'b0;
`ifdef KEYPAD_AUTO_REPEAT_EN
                    hold_d  = '0;
`endif
                    if (frame_code == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        scan_data_d = frame_code;
                        state_d     = ST_LOAD;
                    end
                end
`ifdef KEYPAD_AUTO_REPEAT_EN
                else if (frame_end) begin
                    if (hold_q == HOLD_LAST) begin
                        hold_d  = '0;
                        valid_d = 1'b0;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q        <= '0;
            key_col_q    <= 3'b001;
            raw_q        <= '0;
            prev_q       <= '0;
            stable_cnt_q <= '0;
            state_q      <= ST_IDLE;
            scan_data_q  <= '0;
            valid_q      <= 1'b0;
`ifdef KEYPAD_AUTO_REPEAT_EN
            hold_q       <= '0;
`endif
        end else begin
            div_q        <= div_d;
            key_col_q    <= key_col_d;
            raw_q        <= raw_d;
            prev_q       <= prev_d;
            stable_cnt_q <= stable_cnt_d;
            state_q      <= state_d;
            scan_data_q  <= scan_data_d;
            valid_q      <= valid_d;
`ifdef KEYPAD_AUTO_REPEAT_EN
            hold_q       <= hold_d;
`endif
        end
    end

    assign key_col   = key_col_q;
    assign Scan_data = scan_data_q;
    assign valid     = valid_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: directed scenarios plus randomized key activity against a frame-level model.
// Honors KEYPAD_AUTO_REPEAT_EN when it is defined for the build.
module tb_keypad_scanner;

    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned DEB      = 3;
    localparam int unsigned REP      = 4;
    localparam int unsigned FRAME    = 3 * SCAN_DIV;

    // key positions are row*3+col
    localparam logic [11:0] P_1    = 12'h001;
    localparam logic [11:0] P_2    = 12'h002;
    localparam logic [11:0] P_5    = 12'h010;
    localparam logic [11:0] P_7    = 12'h040;
    localparam logic [11:0] P_STAR = 12'h200;
    localparam logic [11:0] P_0    = 12'h400;
    localparam logic [11:0] P_HASH = 12'h800;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  key_row;
    logic [2:0]  key_col;
    logic [11:0] Scan_data;
    logic        valid;
    logic [11:0] pressed = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        key_row = '0;
        for (int r = 0; r < 4; r++) key_row[r] = |(pressed[r*3 +: 3] & key_col);
    end

    keypad_scanner #(
        .SCAN_DIV      (SCAN_DIV),
        .DEBOUNCE_CNT  (DEB),
        .REPEAT_FRAMES (REP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_row   (key_row),
        .key_col   (key_col),
        .Scan_data (Scan_data),
        .valid     (valid)
    );

    // ---------------- reference model (frame history, key arithmetic) ----------------
    int          m_cyc;
    logic [11:0] m_samp;
    logic [11:0] m_scan;
    logic        m_valid, m_held, m_pend;
    int          m_hold;
    logic [11:0] hist[$];
    int          mcol;
    logic [11:0] mcode;
    bit          mstable;

    function automatic logic [11:0] key_code(input logic [11:0] s);
        int n = 0;
        int p = 0;
        for (int i = 0; i < 12; i++) if (s[i]) begin n++; p = i; end
        if (n != 1) return 12'h000;
        if (p < 9) return 12'(1) << (p + 1);
        if (p == 9) return 12'h400;
        if (p == 10) return 12'h001;
        return 12'h800;
    endfunction

    function automatic logic [2:0] exp_col();
        return 3'(1) << ((m_cyc / SCAN_DIV) % 3);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_cyc = 0; m_samp = '0; m_scan = '0; m_valid = 1'b0;
            m_held = 1'b0; m_pend = 1'b0; m_hold = 0; hist.delete();
        end else begin
            if (m_pend) begin m_valid = 1'b1; m_held = 1'b1; m_pend = 1'b0; end
            mcol = (m_cyc / SCAN_DIV) % 3;
            if (m_cyc % SCAN_DIV == SCAN_DIV - 1)
                for (int r = 0; r < 4; r++) m_samp[r*3 + mcol] = pressed[r*3 + mcol];
            if (m_cyc % FRAME == FRAME - 1) begin
                mcode = key_code(m_samp);
                hist.push_back(mcode);
                if (hist.size() > DEB) void'(hist.pop_front());
                mstable = (hist.size() == DEB);
                foreach (hist[i]) if (hist[i] != mcode) mstable = 1'b0;
                if (m_held) begin
                    if (mstable && mcode != m_scan) begin
                        m_valid = 1'b0; m_held = 1'b0; m_hold = 0;
                        if (mcode != '0) begin m_scan = mcode; m_pend = 1'b1; end
                    end
`ifdef KEYPAD_AUTO_REPEAT_EN
                    else begin
                        m_hold++;
                        if (m_hold == REP) begin m_hold = 0; m_valid = 1'b0; m_pend = 1'b1; end
                    end
`endif
                end else if (mstable && mcode != '0 && !m_pend) begin
                    m_scan = mcode; m_pend = 1'b1;
                end
            end
            m_cyc++;
        end
    end

    // ---------------- tasks ----------------
    task automatic do_reset(input logic [11:0] keys);
        pressed = keys;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        pressed = P_5;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (key_col !== 3'b001 || Scan_data !== 12'h000 || valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold col=%b scan=%h valid=%b required col=001 scan=000 valid=0", key_col, Scan_data, valid);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        while (m_cyc < 5) begin
            if (m_cyc == 3) begin
                checks++;
                if (key_col !== 3'b001) begin errors++; $display("FAIL col_cyc3 got=%b required=001", key_col); end
            end
            if (m_cyc == 4) begin
                checks++;
                if (key_col !== 3'b010) begin errors++; $display("FAIL col_cyc4 got=%b required=010", key_col); end
            end
            @(negedge clk);
        end
    endtask

    // continues straight from test_reset with '5' held since cycle 0
    task automatic test_single_press();
        while (m_cyc < 110) begin
            if (m_cyc == 60) pressed = '0;
            checks++;
            if (Scan_data !== m_scan || valid !== m_valid || key_col !== exp_col()) begin
                errors++;
                $display("FAIL single_model cyc=%0d scan=%h/%h valid=%b/%b col=%b/%b", m_cyc, Scan_data, m_scan, valid, m_valid, key_col, exp_col());
            end
            if (m_cyc == 35 || m_cyc == 36 || m_cyc == 37 || m_cyc == 95 || m_cyc == 96) begin
                logic [11:0] es;
                logic        ev;
                es = (m_cyc == 35) ? 12'h000 : 12'h020;
                ev = (m_cyc == 37 || m_cyc == 95);
                checks++;
                if (Scan_data !== es || valid !== ev) begin
                    errors++;
                    $display("FAIL single_fixed cyc=%0d scan=%h valid=%b required scan=%h valid=%b", m_cyc, Scan_data, valid, es, ev);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_bounce();
        do_reset('0);
        while (m_cyc < 140) begin
            if (m_cyc < 96 && m_cyc % FRAME == 0) pressed = ((m_cyc / FRAME) % 2 == 0) ? P_HASH : '0;
            if (m_cyc == 96) pressed = P_HASH;
            checks++;
            if (Scan_data !== m_scan || valid !== m_valid || key_col !== exp_col()) begin
                errors++;
                $display("FAIL bounce_model cyc=%0d scan=%h/%h valid=%b/%b col=%b/%b", m_cyc, Scan_data, m_scan, valid, m_valid, key_col, exp_col());
            end
            if (m_cyc < 96 && valid !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL bounce_quiet cyc=%0d valid=%b required=0", m_cyc, valid);
            end
            if (m_cyc == 134) begin
                checks++;
                if (Scan_data !== 12'h800 || valid !== 1'b1) begin
                    errors++;
                    $display("FAIL bounce_settled scan=%h valid=%b required scan=800 valid=1", Scan_data, valid);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_chord();
        do_reset(P_1 | P_2);
        while (m_cyc < 170) begin
            if (m_cyc == 120) pressed = P_1;
            checks++;
            if (Scan_data !== m_scan || valid !== m_valid || key_col !== exp_col()) begin
                errors++;
                $display("FAIL chord_model cyc=%0d scan=%h/%h valid=%b/%b col=%b/%b", m_cyc, Scan_data, m_scan, valid, m_valid, key_col, exp_col());
            end
            if (m_cyc == 119 || m_cyc == 156 || m_cyc == 160) begin
                logic [11:0] es;
                logic        ev;
                es = (m_cyc == 119) ? 12'h000 : 12'h002;
                ev = (m_cyc == 160);
                checks++;
                if (Scan_data !== es || valid !== ev) begin
                    errors++;
                    $display("FAIL chord_fixed cyc=%0d scan=%h valid=%b required scan=%h valid=%b", m_cyc, Scan_data, valid, es, ev);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_key_switch();
        do_reset(P_0);
        while (m_cyc < 100) begin
            if (m_cyc == 48) pressed = P_STAR;
            checks++;
            if (Scan_data !== m_scan || valid !== m_valid || key_col !== exp_col()) begin
                errors++;
                $display("FAIL switch_model cyc=%0d scan=%h/%h valid=%b/%b col=%b/%b", m_cyc, Scan_data, m_scan, valid, m_valid, key_col, exp_col());
            end
            if (m_cyc == 83 || m_cyc == 84 || m_cyc == 85) begin
                logic [11:0] es;
                logic        ev;
                es = (m_cyc == 83) ? 12'h001 : 12'h400;
                ev = (m_cyc != 84);
                checks++;
                if (Scan_data !== es || valid !== ev) begin
                    errors++;
                    $display("FAIL switch_fixed cyc=%0d scan=%h valid=%b required scan=%h valid=%b", m_cyc, Scan_data, valid, es, ev);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_hold();
        int lows = 0;
        int exp_lows;
`ifdef KEYPAD_AUTO_REPEAT_EN
        exp_lows = 3;
`else
        exp_lows = 0;
`endif
        do_reset(P_7);
        while (m_cyc < 220) begin
            checks++;
            if (Scan_data !== m_scan || valid !== m_valid || key_col !== exp_col()) begin
                errors++;
                $display("FAIL hold_model cyc=%0d scan=%h/%h valid=%b/%b col=%b/%b", m_cyc, Scan_data, m_scan, valid, m_valid, key_col, exp_col());
            end
            if (m_cyc >= 38 && valid !== 1'b1) lows++;
            @(negedge clk);
        end
        checks++;
        if (lows != exp_lows || Scan_data !== 12'h080) begin
            errors++;
            $display("FAIL hold_pulses low_cycles=%0d scan=%h required low_cycles=%0d scan=080", lows, Scan_data, exp_lows);
        end
    endtask

    task automatic test_random();
        do_reset('0);
        for (int seg = 0; seg < 40; seg++) begin
            int          kind;
            int          len;
            logic [11:0] pat;
            kind = $urandom_range(0, 9);
            len  = (kind < 5) ? $urandom_range(10, 80) : $urandom_range(1, 60);
            pat  = '0;
            if (kind < 5 || kind == 7) begin
                pat[$urandom_range(0, 11)] = 1'b1;
            end else if (kind < 7) begin
                pat[$urandom_range(0, 11)] = 1'b1;
                pat[$urandom_range(0, 11)] = 1'b1;
            end
            if (kind == 9) begin
                do_reset(pressed);
            end else begin
                pressed = pat;
                for (int i = 0; i < len; i++) begin
                    if (kind == 7 && $urandom_range(0, 3) == 0) pressed = (pressed == '0) ? pat : '0;
                    checks++;
                    if (Scan_data !== m_scan || valid !== m_valid || key_col !== exp_col()) begin
                        errors++;
                        $display("FAIL random_model seg=%0d cyc=%0d scan=%h/%h valid=%b/%b col=%b/%b", seg, m_cyc, Scan_data, m_scan, valid, m_valid, key_col, exp_col());
                    end
                    @(negedge clk);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_chord();
        test_key_switch();
        test_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached checks=%0d", checks);
        $fatal(1);
    end

endmodule
